demux_1_to_n_deser: RTL and testbench

//   Serial-to-parallel deserializer. It is the receive-side counterpart of the mux_n_to_1 serializer,

---
 rtl/demux_1_to_n_deser.sv | 142 ++++++++++++++
 tb/tb_demux_1_to_n_deser.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_to_n_deser.sv
// ============================================================================
// demux_1_to_n_deser
// ----------------------------------------------------------------------------
// Serial-to-parallel deserializer. This is the receive-side partner of a
// counter-stepped N-to-1 serializer. Each accepted serial bit is steered to
// the bit position named by an internal index counter. That makes the block a
// 1-to-N demux whose select line is the counter. When the last position is
// filled, the word is presented downstream on a valid/ready interface.
//
// Parameters
//   WIDTH_SELECT : width of the bit-index counter
//   WIDTH        : output word width, always 2**WIDTH_SELECT (do not override)
//
// Ports
//   i_clk      : clock, all state changes on the rising edge
//   i_rst      : asynchronous active-high reset
//   i_d        : serial data bit
//   i_valid    : i_d is valid this cycle
//   i_sof      : start of frame, qualified by i_valid; forces this bit to index 0
//   o_in_ready : block can accept i_d this cycle (combinational)
//   o_q        : completed word; bit k is the k-th bit accepted in the word
//   o_valid    : o_q holds an unconsumed word
//   i_ready    : downstream consumes o_q when o_valid && i_ready
//   o_cnt      : index the next accepted bit will be written to
//   o_err      : one-cycle pulse when i_sof discards a partial word
// ============================================================================
module demux_1_to_n_deser #(
   parameter int WIDTH_SELECT = 2,
   parameter int WIDTH        = 2 ** WIDTH_SELECT
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_d,
   input  logic                    i_valid,
   input  logic                    i_sof,
   output logic                    o_in_ready,
   output logic [WIDTH-1:0]        o_q,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [WIDTH_SELECT-1:0] o_cnt,
   output logic                    o_err
);

   // This is the index of the final bit of a word. Landing on it completes the word.
   localparam logic [WIDTH_SELECT-1:0] LAST_IDX = WIDTH_SELECT'(WIDTH - 1);

   // The assembly register only needs the first WIDTH-1 bits.
   // The final bit goes straight from i_d into the output word.
   logic [WIDTH-2:0]        r_asm;
   logic [WIDTH_SELECT-1:0] r_cnt;
   logic [WIDTH-1:0]        r_q;
   logic                    r_valid;
   logic                    r_err;

   logic w_in_ready;
   logic w_accept;
   logic w_take;
   logic w_sof_accept;
   logic w_done;

   // Handshake decode.
   // The block stalls only when the incoming bit would complete a word while
   // the previous word is still held and not being taken this cycle. A
   // start-of-frame bit never completes a word, so it is never stalled.
   always_comb begin
      w_in_ready   = !(r_valid && !i_ready && (r_cnt == LAST_IDX) && !i_sof);
      w_accept     = i_valid && w_in_ready;
      w_take       = r_valid && i_ready;
      w_sof_accept = w_accept && i_sof;
      w_done       = w_accept && !i_sof && (r_cnt == LAST_IDX);
   end

   // Bit-index counter.
   // A start-of-frame bit always occupies index 0, so the next bit goes to index 1.
   // Otherwise the counter advances on each accepted bit.
   // It wraps back to 0 only when a word completes.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (w_sof_accept) begin
         r_cnt <= WIDTH_SELECT'(1);
      end else if (w_done) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= r_cnt + WIDTH_SELECT'(1);
      end
   end

   // Assembly register: the demux itself.
   // The accepted bit is written into the slot selected by the counter.
   // A start-of-frame bit always overwrites slot 0. Stale bits in the higher
   // slots are harmless, because they are rewritten before the word completes.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_asm <= '0;
      end else if (w_sof_accept) begin
         r_asm[0] <= i_d;
      end else if (w_accept) begin
         for (int k = 0; k < WIDTH - 1; k++) begin
            if (r_cnt == WIDTH_SELECT'(k)) begin
               r_asm[k] <= i_d;
            end
         end
      end
   end

   // Output word and its valid flag.
   // A completing bit loads the new word and raises valid. A same-cycle take
   // of the old word is still lossless, because the old word has already left
   // on this edge. A take with no new word drops valid and leaves o_q as it
   // was. The word therefore stays stable while the downstream is stalled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q     <= '0;
         r_valid <= 1'b0;
      end else if (w_done) begin
         r_q     <= {i_d, r_asm};
         r_valid <= 1'b1;
      end else if (w_take) begin
         r_valid <= 1'b0;
      end
   end

   // Error pulse.
   // This pulses for one cycle when a start-of-frame bit throws away bits
   // that were already collected for the current word. A start of frame
   // that arrives on a word boundary is not an error.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_sof_accept && (r_cnt != '0);
      end
   end

   assign o_in_ready = w_in_ready;
   assign o_q        = r_q;
   assign o_valid    = r_valid;
   assign o_cnt      = r_cnt;
   assign o_err      = r_err;

endmodule

// File: tb/tb_demux_1_to_n_deser.sv
// ============================================================================
// tb_demux_1_to_n_deser
// ----------------------------------------------------------------------------
// Bench for the deserializer. The main instance uses WIDTH_SELECT=2 and is
// followed by a behavioural model. The model keeps the bits of the current
// word in a queue, plus the held output word. A small second instance with
// WIDTH_SELECT=1 covers the narrow case with literal expectations.
// ============================================================================
module tb_demux_1_to_n_deser;

   localparam int WS = 2;
   localparam int W  = 2 ** WS;

   logic          clk = 1'b0;
   logic          i_rst = 1'b0;
   logic          i_d = 1'b0, i_valid = 1'b0, i_sof = 1'b0, i_ready = 1'b0;
   logic          o_in_ready, o_valid, o_err;
   logic [W-1:0]  o_q;
   logic [WS-1:0] o_cnt;

   logic          d1 = 1'b0, v1 = 1'b0, sof1 = 1'b0, rdy1 = 1'b0;
   logic          inrdy1, valid1, err1;
   logic [1:0]    q1;
   logic [0:0]    cnt1;

   int checks = 0;
   int errors = 0;

   // Model state: bits of the word in progress, held word, valid and error flags.
   bit         partial[$];
   logic [W-1:0] mQ = '0;
   logic       mValid = 1'b0;
   logic       mErr = 1'b0;
   logic       lastAccept = 1'b1;
   logic       seenReady;

   always #5 clk = ~clk;

   demux_1_to_n_deser #(.WIDTH_SELECT(WS)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_d(i_d), .i_valid(i_valid), .i_sof(i_sof),
      .o_in_ready(o_in_ready), .o_q(o_q), .o_valid(o_valid), .i_ready(i_ready),
      .o_cnt(o_cnt), .o_err(o_err)
   );

   demux_1_to_n_deser #(.WIDTH_SELECT(1)) dut1 (
      .i_clk(clk), .i_rst(i_rst), .i_d(d1), .i_valid(v1), .i_sof(sof1),
      .o_in_ready(inrdy1), .o_q(q1), .o_valid(valid1), .i_ready(rdy1),
      .o_cnt(cnt1), .o_err(err1)
   );

   // Compare one value and report a failure line if it differs.
   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Compare every output of the main instance against the model.
   task automatic checkOutput();
      logic expReady;
      expReady = !(mValid && !i_ready && (partial.size() == W - 1) && !i_sof);
      checkVal("in_ready", 32'(o_in_ready), 32'(expReady));
      checkVal("q",        32'(o_q),        32'(mQ));
      checkVal("valid",    32'(o_valid),    32'(mValid));
      checkVal("cnt",      32'(o_cnt),      32'(partial.size()));
      checkVal("err",      32'(o_err),      32'(mErr));
   endtask

   // Drive one cycle of inputs, check the outputs, then advance the model.
   task automatic applyStimulus(input logic d, input logic v, input logic sof, input logic rdy);
      logic expReady, accept, take, done, nErr, nValid;
      logic [W-1:0] nQ;
      @(negedge clk);
      i_d = d; i_valid = v; i_sof = sof; i_ready = rdy;
      #1;
      checkOutput();
      seenReady = o_in_ready;
      expReady = !(mValid && !rdy && (partial.size() == W - 1) && !sof);
      accept = v && expReady;
      take   = mValid && rdy;
      done   = 1'b0;
      nErr   = 1'b0;
      nQ     = mQ;
      if (accept) begin
         if (sof) begin
            nErr = (partial.size() != 0);
            partial.delete();
            partial.push_back(d);
         end else begin
            partial.push_back(d);
            if (partial.size() == W) begin
               for (int k = 0; k < W; k++) nQ[k] = partial[k];
               done = 1'b1;
               partial.delete();
            end
         end
      end
      nValid = done ? 1'b1 : (take ? 1'b0 : mValid);
      lastAccept = accept || !v;
      @(posedge clk);
      mQ = nQ; mValid = nValid; mErr = nErr;
      #1;
   endtask

   task automatic sendWord(input logic [3:0] w, input logic rdy);
      for (int k = 0; k < 4; k++) applyStimulus(w[k], 1'b1, 1'b0, rdy);
   endtask

   // Assert reset between clock edges and confirm the outputs clear at once.
   task automatic doReset();
      @(negedge clk);
      i_valid = 1'b0; i_sof = 1'b0; v1 = 1'b0; sof1 = 1'b0;
      #2 i_rst = 1'b1;
      #1;
      checkVal("rst_valid", 32'(o_valid), 32'd0);
      checkVal("rst_q",     32'(o_q),     32'd0);
      checkVal("rst_cnt",   32'(o_cnt),   32'd0);
      checkVal("rst_err",   32'(o_err),   32'd0);
      partial.delete(); mQ = '0; mValid = 1'b0; mErr = 1'b0; lastAccept = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
   endtask

   task automatic step1(input logic d, input logic v, input logic sof);
      @(negedge clk);
      d1 = d; v1 = v; sof1 = sof; rdy1 = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic rd, rv, rs, rr;
      doReset();

      // Stream 1,0,1,1 with a consumer that is always ready.
      applyStimulus(1, 1, 0, 1); applyStimulus(0, 1, 0, 1);
      applyStimulus(1, 1, 0, 1); applyStimulus(1, 1, 0, 1);
      checkVal("t1_q", 32'(o_q), 32'hD);
      checkVal("t1_valid", 32'(o_valid), 32'd1);
      applyStimulus(0, 0, 0, 1);
      checkVal("t1_valid_drop", 32'(o_valid), 32'd0);

      // Send back-to-back words A then 5.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(k[0] ? 1'b1 : 1'b0, 1, 0, 1);
         checkVal("t2_ready_a", 32'(seenReady), 32'd1);
      end
      checkVal("t2_qa", 32'(o_q), 32'hA);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(k[0] ? 1'b0 : 1'b1, 1, 0, 1);
         checkVal("t2_ready_5", 32'(seenReady), 32'd1);
      end
      checkVal("t2_q5", 32'(o_q), 32'h5);
      checkVal("t2_valid", 32'(o_valid), 32'd1);

      // Stall the consumer after word 3.
      sendWord(4'h3, 1'b1);
      applyStimulus(1, 1, 0, 0); applyStimulus(0, 1, 0, 0); applyStimulus(1, 1, 0, 0);
      checkVal("t3_ready3", 32'(seenReady), 32'd1);
      applyStimulus(1, 1, 0, 0);
      checkVal("t3_stall", 32'(seenReady), 32'd0);
      checkVal("t3_hold", 32'(o_q), 32'h3);
      applyStimulus(1, 1, 0, 1);
      checkVal("t3_release", 32'(seenReady), 32'd1);
      checkVal("t3_q", 32'(o_q), 32'hD);
      checkVal("t3_valid", 32'(o_valid), 32'd1);
      applyStimulus(0, 0, 0, 1);

      // A start of frame after two bits discards them and raises an error.
      applyStimulus(1, 1, 0, 1); applyStimulus(1, 1, 0, 1);
      applyStimulus(1, 1, 1, 1);
      checkVal("t4_err", 32'(o_err), 32'd1);
      checkVal("t4_cnt", 32'(o_cnt), 32'd1);
      applyStimulus(0, 1, 0, 1);
      checkVal("t4_err_clr", 32'(o_err), 32'd0);
      applyStimulus(1, 1, 0, 1); applyStimulus(0, 1, 0, 0);
      checkVal("t4_q", 32'(o_q), 32'h5);

      // Reset mid-word while a word is held, then assemble a clean word.
      applyStimulus(1, 1, 0, 0); applyStimulus(1, 1, 0, 0);
      doReset();
      sendWord(4'h6, 1'b1);
      checkVal("t5_q", 32'(o_q), 32'h6);

      // Random traffic. The source holds any bit that was not accepted.
      rd = 0; rv = 0; rs = 0;
      for (int n = 0; n < 400; n++) begin
         if (lastAccept) begin
            rd = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 7) == 0);
         end
         rr = ($urandom_range(0, 2) != 0);
         applyStimulus(rd, rv, rs, rr);
      end
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);

      // Narrow instance: bits 0,1 give 2'b10; a start of frame at index 0 is clean.
      doReset();
      step1(0, 1, 0); step1(1, 1, 0);
      checkVal("w1_q", 32'(q1), 32'h2);
      checkVal("w1_valid", 32'(valid1), 32'd1);
      step1(1, 1, 1);
      checkVal("w1_err", 32'(err1), 32'd0);
      checkVal("w1_cnt", 32'(cnt1), 32'd1);
      step1(0, 1, 0);
      checkVal("w1_q2", 32'(q1), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
